// File: rtl/result_serializer.sv
// Result serializer: captures wide result words into a small FIFO and streams
// each word out LSB slice first as OUT_WIDTH beats with a valid/ready handshake.
module result_serializer #(
  parameter int DATA_WIDTH = 64,
  parameter int OUT_WIDTH  = 8,
  parameter int DEPTH      = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic                           clear_i,
  input  logic                           valid_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic                           ready_i,
  output logic                           valid_o,
  output logic [OUT_WIDTH-1:0]           data_o,
  output logic                           last_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           overflow_o
);

  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [0:0]    S_IDLE    = 1'b0;
  localparam logic [0:0]    S_SHIFT   = 1'b1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [0:0]            state_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [BW-1:0]         beat_q;
  logic                  overflow_q;

  logic push, wr, drop, xfer, pop;
  logic [DATA_WIDTH-1:0] head;

  // Fullness is judged on the count at the start of the cycle, so a word
  // arriving on a full FIFO is dropped even if the head pops this same cycle.
  assign push = valid_i & en_i & ~clear_i;
  assign wr   = push & (count_q != FULL_CNT);
  assign drop = push & (count_q == FULL_CNT);
  assign xfer = valid_o & ready_i;
  assign pop  = xfer & (beat_q == LAST_BEAT);
  assign head = mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (wr && !pop)      count_d = count_q + CW'(1);
    else if (!wr && pop) count_d = count_q - CW'(1);
  end

  // Storage deliberately has no reset; outputs are gated by valid_o instead.
  always_ff @(posedge clk_i) begin
    if (wr) mem[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr)   wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (drop) overflow_q <= 1'b1;
      if (xfer) beat_q <= pop ? '0 : beat_q + BW'(1);
      count_q <= count_d;
      state_q <= (count_d != '0) ? S_SHIFT : S_IDLE;
    end
  end

  assign valid_o    = (state_q == S_SHIFT);
  assign last_o     = valid_o & (beat_q == LAST_BEAT);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

  always_comb begin
    data_o = '0;
    if (valid_o) data_o = head[beat_q*OUT_WIDTH +: OUT_WIDTH];
  end

endmodule
